// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared select encodings, stage tag type and widths for the forwarding logic
package pipe_pkg;

    localparam int NREG_W = 5;
    localparam int CNT_W  = 16;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_DM = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              wr_en;
        logic              is_load;
    } stage_tag_t;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } stall_state_t;

    // R0 is hardwired, so a write to it never produces a forwardable value
    function automatic logic tag_hit(input stage_tag_t tag, input logic [NREG_W-1:0] src);
        return tag.valid && tag.wr_en && (tag.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority compare of one source register against the EX/DM/WB tags
module fwd_select
    import pipe_pkg::*;
(
    input  logic [NREG_W-1:0] src,
    input  stage_tag_t        ex,
    input  stage_tag_t        dm,
    input  stage_tag_t        wb,
    output logic [1:0]        sel,
    output logic              hazard
);

    // Load data only exists from DM onwards, so those stages forward regardless of is_load
    logic unused_load_bits;
    assign unused_load_bits = dm.is_load ^ wb.is_load;

    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (tag_hit(ex, src)) begin
            if (ex.is_load) hazard = 1'b1;
            else            sel    = SEL_EX;
        end else if (tag_hit(dm, src)) begin
            sel = SEL_DM;
        end else if (tag_hit(wb, src)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/forwarding_control.sv
// rtl/forwarding_control.sv - operand forwarding selects, load-use stall and stall counter
module forwarding_control
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] RA,
    input  logic [NREG_W-1:0] RB,
    input  logic [NREG_W-1:0] RW,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              id_use_imm,
    output logic [1:0]        mux_sel_A,
    output logic [1:0]        mux_sel_B,
    output logic              imm_sel,
    output logic              stall,
    output logic [NREG_W-1:0] RW_wb,
    output logic              wb_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_tag_t   ex_tag, dm_tag, wb_tag, id_tag;
    stall_state_t state;
    logic [1:0]   sel_a, sel_b;
    logic         haz_a, haz_b;

    assign id_tag = '{valid: id_valid, rd: RW, wr_en: id_wr_en, is_load: id_is_load};

    fwd_select u_fwd_a (
        .src    (RA),
        .ex     (ex_tag),
        .dm     (dm_tag),
        .wb     (wb_tag),
        .sel    (sel_a),
        .hazard (haz_a)
    );

    fwd_select u_fwd_b (
        .src    (RB),
        .ex     (ex_tag),
        .dm     (dm_tag),
        .wb     (wb_tag),
        .sel    (sel_b),
        .hazard (haz_b)
    );

    // An immediate B operand never reads RB, so its hazard is irrelevant
    assign imm_sel   = id_use_imm && id_valid;
    assign stall     = id_valid && (haz_a || (haz_b && !id_use_imm));
    assign mux_sel_A = stall ? SEL_RF : sel_a;
    assign mux_sel_B = (stall || imm_sel) ? SEL_RF : sel_b;
    assign RW_wb     = wb_tag.rd;
    assign wb_we     = wb_tag.valid && wb_tag.wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag    <= '0;
            dm_tag    <= '0;
            wb_tag    <= '0;
            stall_cnt <= '0;
        end else begin
            ex_tag <= stall ? '0 : id_tag;
            dm_tag <= ex_tag;
            wb_tag <= dm_tag;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:    if (stall) state <= ST_BUBBLE;
                ST_BUBBLE: state <= ST_RUN;
            endcase
        end
    end

    // After one bubble the load sits in DM, so the same instruction can never stall twice
    assert property (@(posedge clk) disable iff (rst) (state == ST_BUBBLE) |-> !stall);

endmodule
